// File: rtl/firebird7_in_gate1_tessent_scanmux_secure_nway.sv
// N-way secure spare scan mux for the gate1 IJTAG network.
// Select lives in a shift/update register; upper channels need unlock.
module firebird7_in_gate1_tessent_scanmux_secure_nway #(
  parameter int NUM_IN      = 4,
  parameter int SEL_W       = $clog2(NUM_IN),
  parameter int SECURE_BASE = 2
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_se,
  input  logic              ijtag_ce,
  input  logic              ijtag_ue,
  input  logic              ijtag_si,
  output logic              ijtag_so,
  input  logic [NUM_IN-1:0] mux_in,
  output logic              mux_out,
  input  logic              enable_in,
  output logic [NUM_IN-1:0] enable_out,
  input  logic              secure_unlock,
  output logic              lock_violation
);

  logic [SEL_W-1:0] sr;
  logic [SEL_W-1:0] upd;
  logic             viol;
  logic [SEL_W:0]   sr_ext;
  logic [SEL_W-1:0] sr_shift;
  logic             do_shift;
  logic             do_cap;
  logic             do_upd;
  logic             req_ok;
  logic             relock;

  // Decode the single active op and qualify the requested select.
  always_comb begin
    sr_ext   = {ijtag_si, sr};
    sr_shift = sr_ext[SEL_W:1];
    do_shift = ijtag_sel & ijtag_se;
    do_cap   = ijtag_sel & ~ijtag_se & ijtag_ce;
    do_upd   = ijtag_sel & ~ijtag_se & ~ijtag_ce & ijtag_ue;
    req_ok   = (32'(sr) < NUM_IN) &&
               ((32'(sr) < SECURE_BASE) || secure_unlock);
    relock   = ~secure_unlock && (32'(upd) >= SECURE_BASE);
  end

  // Select shift register: shift LSB-out first, or capture active select.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr <= '0;
    end else if (do_shift) begin
      sr <= sr_shift;
    end else if (do_cap) begin
      sr <= upd;
    end
  end

  // Active select: relock to channel 0 beats any accepted update.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      upd <= '0;
    end else if (relock) begin
      upd <= '0;
    end else if (do_upd && req_ok) begin
      upd <= sr;
    end
  end

  // Sticky flag for rejected update requests.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      viol <= 1'b0;
    end else if (do_upd && !req_ok) begin
      viol <= 1'b1;
    end
  end

  // One-hot gated enables decoded from the active select.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      enable_out[i] = enable_in & (32'(upd) == i);
    end
  end

  assign mux_out        = mux_in[upd];
  assign ijtag_so       = sr[0];
  assign lock_violation = viol;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_scanmux_secure_nway.sv
// Bench for the N-way secure scan mux.
// Two instances: 4-way/base 2 and 3-way/no secure channels.
module tb_firebird7_in_gate1_tessent_scanmux_secure_nway;

  logic tck = 1'b0;
  logic rst, sel, se, ce, ue, si, unlock, en;
  logic [3:0] mi4;
  logic [2:0] mi3;
  logic so4, mo4, lv4;
  logic so3, mo3, lv3;
  logic [3:0] eo4;
  logic [2:0] eo3;

  int tests = 0;
  int fails = 0;

  int m_sr[2];
  int m_upd[2];
  int m_viol[2];
  int nin[2] = '{4, 3};
  int sbase[2] = '{2, 3};
  int wid[2] = '{2, 2};

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_scanmux_secure_nway #(
    .NUM_IN(4), .SECURE_BASE(2)
  ) dut4 (
    .ijtag_tck(tck), .ijtag_reset(rst), .ijtag_sel(sel),
    .ijtag_se(se), .ijtag_ce(ce), .ijtag_ue(ue),
    .ijtag_si(si), .ijtag_so(so4), .mux_in(mi4),
    .mux_out(mo4), .enable_in(en), .enable_out(eo4),
    .secure_unlock(unlock), .lock_violation(lv4)
  );

  firebird7_in_gate1_tessent_scanmux_secure_nway #(
    .NUM_IN(3), .SECURE_BASE(3)
  ) dut3 (
    .ijtag_tck(tck), .ijtag_reset(rst), .ijtag_sel(sel),
    .ijtag_se(se), .ijtag_ce(ce), .ijtag_ue(ue),
    .ijtag_si(si), .ijtag_so(so3), .mux_in(mi3),
    .mux_out(mo3), .enable_in(en), .enable_out(eo3),
    .secure_unlock(unlock), .lock_violation(lv3)
  );

  // Reference model: select value as an integer, rules applied directly.
  always @(posedge tck) begin
    for (int k = 0; k < 2; k++) begin
      int nsr, nupd, nv, r;
      nsr = m_sr[k]; nupd = m_upd[k]; nv = m_viol[k];
      if (rst) begin
        nsr = 0; nupd = 0; nv = 0;
      end else begin
        if (sel) begin
          if (se) nsr = (m_sr[k] / 2) + (si ? (1 << (wid[k] - 1)) : 0);
          else if (ce) nsr = m_upd[k];
          else if (ue) begin
            r = m_sr[k];
            if (r < nin[k] && (r < sbase[k] || unlock)) nupd = r;
            else nv = 1;
          end
        end
        if (!unlock && m_upd[k] >= sbase[k]) nupd = 0;
      end
      m_sr[k] = nsr; m_upd[k] = nupd; m_viol[k] = nv;
    end
  end

  task automatic tick();
    @(posedge tck);
    @(negedge tck);
  endtask

  task automatic idle();
    sel = 1'b1; se = 1'b0; ce = 1'b0; ue = 1'b0; si = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    se = 1'b1; si = b; tick(); se = 1'b0; si = 1'b0;
  endtask

  task automatic pulse_ue();
    ue = 1'b1; tick(); ue = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    unlock = 1'b0; en = 1'b1; mi4 = 4'b0101; mi3 = 3'b101;
    do_reset();
    tests++; if (mo4 !== 1'b1) begin fails++;
      $display("FAIL reset_mux got %b want 1", mo4); end
    tests++; if (eo4 !== 4'b0001) begin fails++;
      $display("FAIL reset_en got %b want 0001", eo4); end
    tests++; if (so4 !== 1'b0) begin fails++;
      $display("FAIL reset_so got %b want 0", so4); end
    tests++; if (lv4 !== 1'b0) begin fails++;
      $display("FAIL reset_viol got %b want 0", lv4); end
    tests++; if (eo3 !== 3'b001) begin fails++;
      $display("FAIL reset_en3 got %b want 001", eo3); end
  endtask

  task automatic test_select_open();
    shift_bit(1'b1); shift_bit(1'b0); pulse_ue();
    tests++; if (eo4 !== 4'b0010) begin fails++;
      $display("FAIL open_en got %b want 0010", eo4); end
    tests++; if (mo4 !== 1'b0) begin fails++;
      $display("FAIL open_mux got %b want 0", mo4); end
    tests++; if (lv4 !== 1'b0) begin fails++;
      $display("FAIL open_viol got %b want 0", lv4); end
    tests++; if (eo3 !== 3'b010) begin fails++;
      $display("FAIL open_en3 got %b want 010", eo3); end
  endtask

  task automatic test_secure_reject();
    shift_bit(1'b1); shift_bit(1'b1); pulse_ue();
    tests++; if (eo4 !== 4'b0010 || lv4 !== 1'b1) begin fails++;
      $display("FAIL sec_reject got en=%b v=%b want 0010/1", eo4, lv4); end
    tests++; if (eo3 !== 3'b010 || lv3 !== 1'b1) begin fails++;
      $display("FAIL range_reject3 got en=%b v=%b want 010/1", eo3, lv3); end
    tick();
    tests++; if (lv4 !== 1'b1) begin fails++;
      $display("FAIL viol_sticky got %b want 1", lv4); end
    unlock = 1'b1; pulse_ue();
    tests++; if (eo4 !== 4'b1000 || lv4 !== 1'b1) begin fails++;
      $display("FAIL sec_accept got en=%b v=%b want 1000/1", eo4, lv4); end
    tests++; if (eo3 !== 3'b010) begin fails++;
      $display("FAIL unlock_range3 got %b want 010", eo3); end
  endtask

  task automatic test_relock();
    do_reset(); unlock = 1'b1;
    shift_bit(1'b1); shift_bit(1'b1); pulse_ue();
    tests++; if (eo4 !== 4'b1000) begin fails++;
      $display("FAIL relock_setup got %b want 1000", eo4); end
    unlock = 1'b0; tick();
    tests++; if (eo4 !== 4'b0001 || lv4 !== 1'b0) begin fails++;
      $display("FAIL relock got en=%b v=%b want 0001/0", eo4, lv4); end
    unlock = 1'b1; pulse_ue();
    shift_bit(1'b0); shift_bit(1'b1);
    unlock = 1'b0; pulse_ue();
    tests++; if (eo4 !== 4'b0001 || lv4 !== 1'b1) begin fails++;
      $display("FAIL relock_rej got en=%b v=%b want 0001/1", eo4, lv4); end
    do_reset(); unlock = 1'b1;
    shift_bit(1'b1); shift_bit(1'b1); pulse_ue();
    shift_bit(1'b1); shift_bit(1'b0);
    unlock = 1'b0; pulse_ue();
    tests++; if (eo4 !== 4'b0001 || lv4 !== 1'b0) begin fails++;
      $display("FAIL relock_prio got en=%b v=%b want 0001/0", eo4, lv4); end
  endtask

  task automatic test_capture();
    do_reset(); unlock = 1'b1;
    shift_bit(1'b0); shift_bit(1'b1); pulse_ue();
    shift_bit(1'b1); shift_bit(1'b1);
    ce = 1'b1; tick(); ce = 1'b0;
    tests++; if (so4 !== 1'b0) begin fails++;
      $display("FAIL cap_so0 got %b want 0", so4); end
    shift_bit(1'b0);
    tests++; if (so4 !== 1'b1) begin fails++;
      $display("FAIL cap_so1 got %b want 1", so4); end
    se = 1'b1; ue = 1'b1; si = 1'b1; tick(); idle();
    tests++; if (eo4 !== 4'b0100 || so4 !== 1'b0) begin fails++;
      $display("FAIL se_ue got en=%b so=%b want 0100/0", eo4, so4); end
    sel = 1'b0; se = 1'b1; ue = 1'b1; si = 1'b1; tick(); idle();
    tests++; if (eo4 !== 4'b0100 || so4 !== 1'b0) begin fails++;
      $display("FAIL nosel got en=%b so=%b want 0100/0", eo4, so4); end
  endtask

  task automatic test_reset_mid_shift();
    do_reset(); unlock = 1'b0;
    shift_bit(1'b1); shift_bit(1'b1); pulse_ue();
    tests++; if (lv3 !== 1'b1 || eo3 !== 3'b001) begin fails++;
      $display("FAIL nosec3 got v=%b en=%b want 1/001", lv3, eo3); end
    shift_bit(1'b1);
    se = 1'b1; si = 1'b1; rst = 1'b1; tick(); rst = 1'b0; idle();
    tests++; if (so3 !== 1'b0 || lv3 !== 1'b0 || eo3 !== 3'b001)
      begin fails++;
      $display("FAIL rst_mid got so=%b v=%b en=%b want 0/0/001",
               so3, lv3, eo3); end
    tests++; if (so4 !== 1'b0 || lv4 !== 1'b0 || eo4 !== 4'b0001)
      begin fails++;
      $display("FAIL rst_mid4 got so=%b v=%b en=%b want 0/0/0001",
               so4, lv4, eo4); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int r;
      logic [3:0] w4;
      logic [2:0] w3;
      r = int'($urandom_range(0, 99));
      rst = (r < 3);
      sel = ($urandom_range(0, 9) != 0);
      se = $urandom_range(0, 2) == 0;
      ce = $urandom_range(0, 4) == 0;
      ue = $urandom_range(0, 2) == 0;
      si = 1'($urandom);
      if ($urandom_range(0, 5) == 0) unlock = ~unlock;
      en = ($urandom_range(0, 7) != 0);
      mi4 = 4'($urandom); mi3 = 3'($urandom);
      tick();
      w4 = en ? 4'(1 << m_upd[0]) : 4'b0;
      w3 = en ? 3'(1 << m_upd[1]) : 3'b0;
      tests++;
      if (so4 !== 1'(m_sr[0] % 2) || mo4 !== mi4[m_upd[0]] ||
          eo4 !== w4 || lv4 !== 1'(m_viol[0])) begin
        fails++;
        $display("FAIL rand4 c=%0d got so=%b mo=%b en=%b v=%b want %0d/%b/%b/%0d",
                 c, so4, mo4, eo4, lv4, m_sr[0] % 2, mi4[m_upd[0]],
                 w4, m_viol[0]);
      end
      tests++;
      if (so3 !== 1'(m_sr[1] % 2) || mo3 !== mi3[m_upd[1]] ||
          eo3 !== w3 || lv3 !== 1'(m_viol[1])) begin
        fails++;
        $display("FAIL rand3 c=%0d got so=%b mo=%b en=%b v=%b want %0d/%b/%b/%0d",
                 c, so3, mo3, eo3, lv3, m_sr[1] % 2, mi3[m_upd[1]],
                 w3, m_viol[1]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_sr[k] = 0; m_upd[k] = 0; m_viol[k] = 0;
    end
    rst = 1'b1; idle(); unlock = 1'b0; en = 1'b1;
    mi4 = 4'b0101; mi3 = 3'b101;
    test_reset();
    test_select_open();
    test_secure_reject();
    test_relock();
    test_capture();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
